// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and default widths for the CPU memory-port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

endpackage

// File: rtl/mem_arbiter_bus_watchdog.sv
// Counts consecutive enabled cycles and pulses expire_o in the TIMEOUT-th one.
module bus_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic expire_o
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb cnt_d = en_i ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single memory port with registered
// m_* outputs, one-cycle ack pulses and an optional response watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    output logic                i_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ready
);

    localparam int SW = DATA_W / 8;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d, last_q, last_d;
    logic              m_req_q, m_req_d, m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [SW-1:0]     m_wstrb_q, m_wstrb_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic              wd_expire, pick_data;

    generate
        if (TIMEOUT > 0) begin : g_wd
            bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
                .clk      (clk),
                .reset_n  (reset_n),
                .en_i     (state_q == ST_BUSY),
                .expire_o (wd_expire)
            );
        end else begin : g_no_wd
            assign wd_expire = 1'b0;
        end
    endgenerate

    // Only a contested grant looks at history; a lone requester always wins.
    always_comb begin
        pick_data = d_req;
        if (i_req && d_req && RR_MODE != 0) pick_data = (last_q == OWN_FETCH);
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wstrb_d = m_wstrb_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d = ST_BUSY;
                    m_req_d = 1'b1;
                    owner_d = pick_data ? OWN_DATA : OWN_FETCH;
                    last_d  = owner_d;
                    if (pick_data) begin
                        m_we_d    = d_we;
                        m_addr_d  = d_addr;
                        m_wdata_d = d_wdata;
                        m_wstrb_d = d_wstrb;
                    end else begin
                        m_we_d    = 1'b0;
                        m_addr_d  = i_addr;
                        m_wdata_d = '0;
                        m_wstrb_d = '0;
                    end
                end
            end
            ST_BUSY: begin
                // m_ready coinciding with expiry counts as a clean completion.
                if (m_ready || wd_expire) begin
                    state_d = ST_RESP;
                    m_req_d = 1'b0;
                    if (owner_q == OWN_DATA) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = !m_ready;
                        d_rdata_d = m_ready ? m_rdata : '0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = !m_ready;
                        i_rdata_d = m_ready ? m_rdata : '0;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_FETCH;
            last_q    <= OWN_FETCH;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_rdata = i_rdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign d_rdata = d_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 is fixed priority without watchdog,
// instance 1 is round-robin with TIMEOUT=8. Both share clock and reset.
module tb_mem_arbiter;

    localparam int AW = 32, DW = 32, SW = DW / 8;

    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]         i_req, i_ack, i_err, d_req, d_we, d_ack, d_err, m_req, m_we, m_ready;
    logic [1:0][AW-1:0] i_addr, d_addr, m_addr;
    logic [1:0][DW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
    logic [1:0][SW-1:0] d_wstrb, m_wstrb;

    int errors = 0, checks = 0;
    int mem_wait[2];
    int wcnt[2];
    bit mem_hang[2];
    bit force_rdy[2];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]), .i_err(i_err[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_wstrb(d_wstrb[0]),
        .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .d_err(d_err[0]),
        .m_req(m_req[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]), .m_wstrb(m_wstrb[0]),
        .m_rdata(m_rdata[0]), .m_ready(m_ready[0]));

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(8)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]), .i_err(i_err[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_wstrb(d_wstrb[1]),
        .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .d_err(d_err[1]),
        .m_req(m_req[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]), .m_wstrb(m_wstrb[1]),
        .m_rdata(m_rdata[1]), .m_ready(m_ready[1]));

    function automatic logic [31:0] mfun(input logic [31:0] a);
        if (a == 32'h4) return 32'h00C000EF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory: answers after mem_wait wait states, or never while hung.
    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (!m_req[k] || m_ready[k]) wcnt[k] <= 0;
            else                         wcnt[k] <= wcnt[k] + 1;

    always_comb
        for (int k = 0; k < 2; k++) begin
            m_ready[k] = force_rdy[k] || (m_req[k] && !mem_hang[k] && (wcnt[k] >= mem_wait[k]));
            m_rdata[k] = mfun(m_addr[k]);
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_txn(input int k, input bit dat, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] st, input int wt,
                           output int lat, output int bz, output logic [31:0] rd, output bit er);
        bit got = 0;
        int n = 0;
        lat = 0; bz = 0; rd = '0; er = 0;
        mem_wait[k] = wt;
        if (dat) begin
            d_req[k] = 1; d_we[k] = we; d_addr[k] = a; d_wdata[k] = wd; d_wstrb[k] = st;
        end else begin
            i_req[k] = 1; i_addr[k] = a;
        end
        while (!got && n < 64) begin
            @(negedge clk); n++;
            chk("other_ack", dat ? i_ack[k] : d_ack[k], 0);
            if (m_req[k]) begin
                bz++;
                chk("m_addr", m_addr[k], a);
                chk("m_we", m_we[k], dat & we);
                chk("m_wstrb", m_wstrb[k], dat ? st : 4'h0);
                if (dat) chk("m_wdata", m_wdata[k], wd);
            end
            if (dat ? d_ack[k] : i_ack[k]) begin
                got = 1; lat = n;
                rd = dat ? d_rdata[k] : i_rdata[k];
                er = dat ? d_err[k] : i_err[k];
            end
        end
        chk("ack_seen", got, 1);
        if (dat) d_req[k] = 0; else i_req[k] = 0;
        @(negedge clk);
        chk("ack_pulse", dat ? d_ack[k] : i_ack[k], 0);
        chk("rdata_hold", dat ? d_rdata[k] : i_rdata[k], rd);
    endtask

    // Both ports request; ord[j]=1 when the j-th ack went to data.
    task automatic both_run(input int k, input int n, input bit keep, output logic [7:0] ord);
        int got = 0, guard = 0;
        ord = '0; mem_wait[k] = 0;
        i_req[k] = 1; i_addr[k] = 32'h40; d_req[k] = 1; d_we[k] = 0; d_addr[k] = 32'h80;
        while (got < n && guard < 200) begin
            @(negedge clk); guard++;
            if (d_ack[k]) begin ord[got] = 1'b1; got++; if (!keep) d_req[k] = 0; end
            else if (i_ack[k]) begin ord[got] = 1'b0; got++; if (!keep) i_req[k] = 0; end
        end
        chk("both_done", got, n);
        i_req[k] = 0; d_req[k] = 0;
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
    endtask

    // Transaction-level reference: pending sets, last winner, per-grant wait.
    task automatic rand_test(input int cycles);
        bit snap_i[2], snap_d[2], infl[2], own[2], last[2], pm[2], dwe[2];
        int gcyc[2], gwait[2];
        logic [31:0] ia[2], da[2], dw[2];
        logic [3:0] ds[2];
        bit w;
        for (int k = 0; k < 2; k++) begin
            snap_i[k] = 0; snap_d[k] = 0; infl[k] = 0; own[k] = 0; last[k] = 0; pm[k] = 0;
            dwe[k] = 0; gcyc[k] = 0; gwait[k] = 0; ia[k] = 0; da[k] = 0; dw[k] = 0; ds[k] = 0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (m_req[k] && !pm[k]) begin
                    chk("rnd_grant_expected", snap_i[k] | snap_d[k], 1);
                    if (snap_i[k] && snap_d[k]) w = (k == 1) ? !last[k] : 1'b1;
                    else                        w = snap_d[k];
                    chk("rnd_addr", m_addr[k], w ? da[k] : ia[k]);
                    chk("rnd_we", m_we[k], w ? dwe[k] : 1'b0);
                    chk("rnd_wstrb", m_wstrb[k], w ? ds[k] : 4'h0);
                    if (w) chk("rnd_wdata", m_wdata[k], dw[k]);
                    infl[k] = 1; own[k] = w; last[k] = w; gcyc[k] = c; gwait[k] = mem_wait[k];
                end
                pm[k] = m_req[k];
                if (i_ack[k] || d_ack[k]) begin
                    chk("rnd_ack_inflight", infl[k], 1);
                    chk("rnd_ack_port", {d_ack[k], i_ack[k]}, own[k] ? 2'b10 : 2'b01);
                    chk("rnd_rdata", own[k] ? d_rdata[k] : i_rdata[k], mfun(own[k] ? da[k] : ia[k]));
                    chk("rnd_err", i_err[k] | d_err[k], 0);
                    chk("rnd_lat", c - gcyc[k], gwait[k] + 1);
                    infl[k] = 0;
                    if (own[k]) d_req[k] = 0; else i_req[k] = 0;
                end
                if (!m_req[k]) mem_wait[k] = $urandom_range(0, 3);
                if (!i_req[k] && $urandom_range(0, 2) == 0) begin
                    ia[k] = $urandom & 32'hFFFFFFFC; i_addr[k] = ia[k]; i_req[k] = 1;
                end
                if (!d_req[k] && $urandom_range(0, 2) == 0) begin
                    da[k] = $urandom & 32'hFFFFFFFC; dw[k] = $urandom; ds[k] = 4'($urandom);
                    dwe[k] = 1'($urandom);
                    d_addr[k] = da[k]; d_wdata[k] = dw[k]; d_wstrb[k] = ds[k]; d_we[k] = dwe[k];
                    d_req[k] = 1;
                end
                snap_i[k] = i_req[k]; snap_d[k] = d_req[k];
            end
        end
        i_req = '0; d_req = '0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        bit          dat;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wt;
        int          exp_lat;
        int          exp_bz;
    } vec_t;

    initial begin
        vec_t vt[6];
        int lat, bz, grants, acks, held, got;
        logic [31:0] rd;
        logic [7:0] ord;
        bit er, pm;

        i_req = '0; d_req = '0; d_we = '0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_wait[0] = 0; mem_wait[1] = 0; mem_hang[0] = 0; mem_hang[1] = 0;
        force_rdy[0] = 0; force_rdy[1] = 0;

        reset_n = 0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_m_req", m_req[k], 0);
            chk("rst_acks", {i_ack[k], d_ack[k], i_err[k], d_err[k]}, 0);
            chk("rst_rdata", {i_rdata[k], d_rdata[k]}, 0);
            chk("rst_m_bus", {m_addr[k], m_we[k], m_wstrb[k]}, 0);
        end
        reset_n = 1;
        @(negedge clk);

        // Fetch, zero-wait memory
        run_txn(0, 0, 0, 32'h4, 32'h0, 4'h0, 0, lat, bz, rd, er);
        chk("t1_lat", lat, 2);
        chk("t1_rdata", rd, 32'h00C000EF);
        chk("t1_err", er, 0);

        vt[0] = '{0, 0, 32'h00000004, 32'h0,        4'h0, 0, 2, 1};
        vt[1] = '{1, 1, 32'h00000100, 32'hDEADBEEF, 4'hF, 2, 4, 3};
        vt[2] = '{0, 0, 32'h00000200, 32'h0,        4'h0, 1, 3, 2};
        vt[3] = '{1, 1, 32'h00000204, 32'h11223344, 4'h5, 0, 2, 1};
        vt[4] = '{1, 0, 32'h80000000, 32'h0BADF00D, 4'h3, 3, 5, 4};
        vt[5] = '{1, 1, 32'hFFFFFFFC, 32'hCAFEF00D, 4'hA, 1, 3, 2};
        for (int k = 0; k < 2; k++)
            for (int v = 0; v < 6; v++) begin
                run_txn(k, vt[v].dat, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].strb, vt[v].wt,
                        lat, bz, rd, er);
                chk("vec_lat", lat, vt[v].exp_lat);
                chk("vec_busy", bz, vt[v].exp_bz);
                chk("vec_rdata", rd, mfun(vt[v].addr));
                chk("vec_err", er, 0);
            end

        // Simultaneous requests
        pulse_reset();
        both_run(0, 2, 0, ord);
        chk("fp_order_DI", ord[1:0], 2'b01);
        both_run(0, 3, 1, ord);
        chk("fp_starve_DDD", ord[2:0], 3'b111);
        pulse_reset();
        both_run(1, 4, 1, ord);
        chk("rr_order_DIDI", ord[3:0], 4'b0101);

        // Fetch request held one cycle past its ack
        grants = 0; acks = 0; held = -1; pm = 0;
        mem_wait[0] = 0; i_addr[0] = 32'h10; i_req[0] = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_req[0] && !pm) grants++;
            pm = m_req[0];
            if (i_ack[0]) begin
                acks++;
                chk("held_ack_le_grant", acks <= grants, 1);
                if (acks == 1) held = 3;
            end
            if (held > 0) begin held--; if (held == 0) i_req[0] = 0; end
        end
        chk("held_grants", grants, 2);
        chk("held_acks", acks, 2);

        // m_ready outside BUSY is ignored
        force_rdy[0] = 1;
        got = 0;
        repeat (5) begin @(negedge clk); if (i_ack[0] || d_ack[0] || m_req[0]) got++; end
        chk("stray_ready", got, 0);
        run_txn(0, 1, 0, 32'h44, 32'h0, 4'h0, 3, lat, bz, rd, er);
        chk("stray_ready_lat", lat, 2);
        force_rdy[0] = 0;

        // Watchdog on instance 1
        mem_hang[1] = 1;
        run_txn(1, 1, 0, 32'h300, 32'h0, 4'h0, 0, lat, bz, rd, er);
        chk("to_busy", bz, 8);
        chk("to_lat", lat, 9);
        chk("to_err", er, 1);
        chk("to_rdata", rd, 0);
        mem_hang[1] = 0;
        run_txn(1, 1, 0, 32'h304, 32'h0, 4'h0, 0, lat, bz, rd, er);
        chk("after_to_err", er, 0);
        chk("after_to_rdata", rd, mfun(32'h304));
        run_txn(1, 0, 0, 32'h308, 32'h0, 4'h0, 7, lat, bz, rd, er);
        chk("to_edge_ready_err", er, 0);
        chk("to_edge_ready_rdata", rd, mfun(32'h308));
        run_txn(1, 0, 0, 32'h30C, 32'h0, 4'h0, 8, lat, bz, rd, er);
        chk("to_late_ready_err", er, 1);
        chk("to_late_ready_rdata", rd, 0);

        // Asynchronous reset in BUSY
        mem_hang[1] = 1;
        d_addr[1] = 32'h500; d_we[1] = 0; d_req[1] = 1;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy", m_req[1], 1);
        #2 reset_n = 0;
        #1;
        chk("rst_async_m_req", m_req[1], 0);
        chk("rst_async_acks", {i_ack[1], d_ack[1]}, 0);
        @(negedge clk);
        reset_n = 1; mem_hang[1] = 0; mem_wait[1] = 0;
        #1 chk("rst_release_m_req", m_req[1], 0);
        @(negedge clk);
        chk("rst_regrant_m_req", m_req[1], 1);
        chk("rst_regrant_addr", m_addr[1], 32'h500);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); if (d_ack[1]) got = 1; end
        chk("rst_regrant_ack", got, 1);
        d_req[1] = 0;
        repeat (4) @(negedge clk);

        pulse_reset();
        rand_test(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
